cy6264_ctrl: RTL and testbench

//  Synchronous initiator for one asynchronous 8Kx8 CY6264-class SRAM.

---
 rtl/cy6264_ctrl_pkg.sv | 28 ++
 rtl/cy6264_ctrl_if.sv | 17 +
 rtl/cy6264_ctrl_timer.sv | 27 ++
 rtl/cy6264_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cy6264_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cy6264_ctrl_pkg.sv
// Shared types and constants for the CY6264 SRAM initiator.
`timescale 1ns/1ps
package cy6264_ctrl_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD_WAIT,
    WR_PULSE,
    WR_HOLD,
    VFY,
    TURN
  } state_t;

  localparam logic NCE1_IDLE = 1'b1;
  localparam logic CE2_IDLE  = 1'b0;
  localparam logic NOE_IDLE  = 1'b1;
  localparam logic NWE_IDLE  = 1'b1;

  function automatic logic [CNT_W-1:0] cnt_len(input int cycles);
    return CNT_W'(cycles);
  endfunction

endpackage

// File: rtl/cy6264_ctrl_if.sv
// Host-side single-beat request/ready/ack bus of the CY6264 initiator.
`timescale 1ns/1ps
interface cy6264_ctrl_if;
  import cy6264_ctrl_pkg::*;

  logic              REQ;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WDATA;
  logic              READY;
  logic              ACK;
  logic [DATA_W-1:0] RDATA;

  modport master (output REQ, WE, ADDR, WDATA, input READY, ACK, RDATA);
  modport slave  (input REQ, WE, ADDR, WDATA, output READY, ACK, RDATA);

endinterface

// File: rtl/cy6264_ctrl_timer.sv
// Per-state cycle counter: reloaded on state entry, flags the state's last cycle.
`timescale 1ns/1ps
module cy6264_ctrl_timer
  import cy6264_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= len - CNT_W'(1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/cy6264_ctrl.sv
// Timed nCE1/CE2/nOE/nWE/A/D cycle generator for one async 8Kx8 SRAM.
// Optional write-verify read-back enabled by defining CY6264_CTRL_VERIFY_EN.
`timescale 1ns/1ps
module cy6264_ctrl
  import cy6264_ctrl_pkg::*;
#(
  parameter int ADDR_SETUP_CYCLES = 1,
  parameter int RD_WAIT_CYCLES    = 4,
  parameter int WR_PULSE_CYCLES   = 3,
  parameter int TURN_CYCLES       = 1
)(
  input  logic              CLK,
  input  logic              nRESET,
  cy6264_ctrl_if.slave      bus,
  output logic              nCE1,
  output logic              CE2,
  output logic              nOE,
  output logic              nWE,
  output logic [ADDR_W-1:0] A,
  inout  wire logic [DATA_W-1:0] D
`ifdef CY6264_CTRL_VERIFY_EN
  ,
  output logic              VERIFY_ERR
`endif
);

  if (ADDR_SETUP_CYCLES < 1) begin : g_bad_setup
    $fatal(1, "ADDR_SETUP_CYCLES must be >= 1");
  end
  if (RD_WAIT_CYCLES < 1) begin : g_bad_rd
    $fatal(1, "RD_WAIT_CYCLES must be >= 1");
  end
  if (WR_PULSE_CYCLES < 1) begin : g_bad_wr
    $fatal(1, "WR_PULSE_CYCLES must be >= 1");
  end
  if (TURN_CYCLES < 1) begin : g_bad_turn
    $fatal(1, "TURN_CYCLES must be >= 1");
  end

  state_t            state, state_next;
  logic              accept, load, last;
  logic              ready_q, ack_q, d_en, we_q, vfy_q;
  logic              we_next, vfy_next;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [CNT_W-1:0]  len;
  logic              nce1_d, ce2_d, noe_d, nwe_d, d_en_d, ack_d, ready_d;

  assign accept = bus.REQ && ready_q;

  cy6264_ctrl_timer u_timer (
    .clk   (CLK),
    .rst_n (nRESET),
    .load  (load),
    .len   (len),
    .last  (last)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = SETUP;
      SETUP:    if (last) state_next = vfy_q ? VFY : (we_q ? WR_PULSE : RD_WAIT);
      RD_WAIT:  if (last) state_next = TURN;
      WR_PULSE: if (last) state_next = WR_HOLD;
`ifdef CY6264_CTRL_VERIFY_EN
      WR_HOLD:  state_next = SETUP;
`else
      WR_HOLD:  state_next = TURN;
`endif
      VFY:      if (last) state_next = TURN;
      TURN:     if (last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // vfy marks the second SETUP pass after a write; only reachable with verify enabled
  assign we_next  = accept ? bus.WE : we_q;
  assign vfy_next = accept ? 1'b0 : ((state == WR_HOLD) ? 1'b1 : vfy_q);
  assign load     = (state_next != state);

  always_comb begin
    case (state_next)
      SETUP:       len = cnt_len(ADDR_SETUP_CYCLES);
      RD_WAIT, VFY: len = cnt_len(RD_WAIT_CYCLES);
      WR_PULSE:    len = cnt_len(WR_PULSE_CYCLES);
      TURN:        len = cnt_len(TURN_CYCLES);
      default:     len = cnt_len(1);
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight from a flop
  always_comb begin
    nce1_d  = NCE1_IDLE;
    ce2_d   = CE2_IDLE;
    noe_d   = NOE_IDLE;
    nwe_d   = NWE_IDLE;
    d_en_d  = 1'b0;
    ack_d   = 1'b0;
    ready_d = (state_next == IDLE);
    case (state_next)
      SETUP: begin
        nce1_d = 1'b0;
        ce2_d  = 1'b1;
        d_en_d = we_next && !vfy_next;
      end
      RD_WAIT, VFY: begin
        nce1_d = 1'b0;
        ce2_d  = 1'b1;
        noe_d  = 1'b0;
      end
      WR_PULSE: begin
        nce1_d = 1'b0;
        ce2_d  = 1'b1;
        nwe_d  = 1'b0;
        d_en_d = 1'b1;
      end
      WR_HOLD: begin
        nce1_d = 1'b0;
        ce2_d  = 1'b1;
        d_en_d = 1'b1;
      end
      TURN:    ack_d = (state != TURN);
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      nCE1    <= NCE1_IDLE;
      CE2     <= CE2_IDLE;
      nOE     <= NOE_IDLE;
      nWE     <= NWE_IDLE;
      A       <= '0;
      d_en    <= 1'b0;
      ack_q   <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      vfy_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      nCE1    <= nce1_d;
      CE2     <= ce2_d;
      nOE     <= noe_d;
      nWE     <= nwe_d;
      d_en    <= d_en_d;
      ack_q   <= ack_d;
      ready_q <= ready_d;
      we_q    <= we_next;
      vfy_q   <= vfy_next;
      if (accept) begin
        A       <= bus.ADDR;
        wdata_q <= bus.WDATA;
      end
      if (state == RD_WAIT && last) rdata_q <= D;
    end
  end

`ifdef CY6264_CTRL_VERIFY_EN
  logic verr_q;
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) verr_q <= 1'b0;
    else         verr_q <= (state == VFY) && last && (D != wdata_q);
  end
  assign VERIFY_ERR = verr_q;
`endif

  assign D         = d_en ? wdata_q : 'z;
  assign bus.READY = ready_q;
  assign bus.ACK   = ack_q;
  assign bus.RDATA = rdata_q;

endmodule

// File: tb/tb_cy6264_ctrl.sv
// Directed bench for cy6264_ctrl against a timed async SRAM model.
`timescale 1ns/1ps
module tb_cy6264_ctrl;
  import cy6264_ctrl_pkg::*;

`ifdef CY6264_CTRL_VERIFY_EN
  localparam int WR_OCC = 11;
  localparam int WR_NOE = 4;
`else
  localparam int WR_OCC = 6;
  localparam int WR_NOE = 0;
`endif
  localparam int RD_OCC = 6;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        nCE1, CE2, nOE, nWE;
  logic [12:0] A;
  wire  [7:0]  D;
`ifdef CY6264_CTRL_VERIFY_EN
  logic        VERIFY_ERR;
`endif

  int checks = 0;
  int failures = 0;

  always #12.5 CLK = ~CLK;

  cy6264_ctrl_if bus ();

  cy6264_ctrl #(
    .ADDR_SETUP_CYCLES (1),
    .RD_WAIT_CYCLES    (4),
    .WR_PULSE_CYCLES   (3),
    .TURN_CYCLES       (1)
  ) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus),
    .nCE1   (nCE1),
    .CE2    (CE2),
    .nOE    (nOE),
    .nWE    (nWE),
    .A      (A),
    .D      (D)
`ifdef CY6264_CTRL_VERIFY_EN
    ,
    .VERIFY_ERR (VERIFY_ERR)
`endif
  );

  // Async SRAM model: tAA 100 ns, tDOE 40 ns, output held 40 ns after deselect
  logic [7:0] mem [0:8191];
  realtime    t_addr = 0.0, t_oe = 0.0, t_off = 0.0;
  logic       m_en = 1'b0;
  logic [7:0] m_val = 8'h00;
  logic       sel;
  logic       corrupt_en = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (D[i]);
  end
  assign D = m_en ? m_val : 'z;

  initial for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h96;

  always @(A) t_addr = $realtime;
  always @(negedge nOE) t_oe = $realtime;

  always @(posedge nWE) begin
    if (!nCE1 && CE2) mem[A] = (corrupt_en && A == 13'h0010) ? (D ^ 8'h01) : D;
  end

  always begin
    #1;
    sel = !nCE1 && CE2 && !nOE && nWE;
    if (sel) begin
      t_off = $realtime;
      if (($realtime - t_addr >= 100.0) && ($realtime - t_oe >= 40.0)) begin
        m_en  = 1'b1;
        m_val = mem[A];
      end else begin
        m_en = 1'b0;
      end
    end else if (m_en && ($realtime - t_off >= 40.0)) begin
      m_en = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one transaction at a negedge and watches every cycle until READY returns
  task automatic txn(input string tag, input logic we, input logic [12:0] addr,
                     input logic [7:0] wdata, input logic [7:0] exp_rd, input bit hold,
                     output logic verr);
    int   k, occ, noe_cnt, nwe_cnt, ack_cnt, ack_k, bad_d, overlap;
    logic [7:0] rd_at_ack;
    occ = -1; noe_cnt = 0; nwe_cnt = 0; ack_cnt = 0; ack_k = -1; bad_d = 0; overlap = 0;
    rd_at_ack = 8'h00; verr = 1'b0;
    bus.REQ = 1'b1; bus.WE = we; bus.ADDR = addr; bus.WDATA = wdata;
    k = 0;
    while (bus.READY !== 1'b1 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check({tag, ".ready_wait"}, bus.READY, 1'b1);
    if (bus.READY !== 1'b1) begin
      bus.REQ = 1'b0;
      return;
    end
    @(negedge CLK);
    for (int i = 1; i <= 25; i++) begin
      if (nOE == 1'b0) noe_cnt++;
      if (nWE == 1'b0) nwe_cnt++;
      if (nOE == 1'b0 && nWE == 1'b0) overlap++;
      if (bus.ACK) begin
        ack_cnt++;
        ack_k = i;
        rd_at_ack = bus.RDATA;
`ifdef CY6264_CTRL_VERIFY_EN
        verr = VERIFY_ERR;
`endif
      end
      if (we && i <= 5 && D !== wdata) bad_d++;
      if ((!we || i > 5) && !m_en && D !== 8'hFF) bad_d++;
      if (bus.READY) begin
        occ = i - 1;
        break;
      end
      @(negedge CLK);
    end
    check({tag, ".occupancy"}, occ, we ? WR_OCC : RD_OCC);
    check({tag, ".ack_count"}, ack_cnt, 1);
    check({tag, ".ack_cycle"}, ack_k, we ? WR_OCC : RD_OCC);
    check({tag, ".nwe_low"}, nwe_cnt, we ? 3 : 0);
    check({tag, ".noe_low"}, noe_cnt, we ? WR_NOE : 4);
    check({tag, ".oe_we_overlap"}, overlap, 0);
    check({tag, ".d_drive"}, bad_d, 0);
    check({tag, ".rdata"}, rd_at_ack, exp_rd);
    if (!hold) bus.REQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic verr;
    int   k, acks;
    bus.REQ = 1'b0; bus.WE = 1'b0; bus.ADDR = '0; bus.WDATA = '0;

    repeat (3) @(negedge CLK);
    check("rst.nce1", nCE1, 1'b1);
    check("rst.ce2", CE2, 1'b0);
    check("rst.noe", nOE, 1'b1);
    check("rst.nwe", nWE, 1'b1);
    check("rst.addr", A, 13'h0000);
    check("rst.d_z", D, 8'hFF);
    check("rst.ready", bus.READY, 1'b0);
    check("rst.ack", bus.ACK, 1'b0);
    check("rst.rdata", bus.RDATA, 8'h00);
    nRESET = 1'b1;
    #1 check("rel.ready_before_edge", bus.READY, 1'b0);
    @(negedge CLK);
    check("rel.ready_first_edge", bus.READY, 1'b1);

    txn("wr_0a5", 1'b1, 13'h00A5, 8'h3C, 8'h00, 1'b0, verr);
    check("wr_0a5.mem", mem[13'h00A5], 8'h3C);
    txn("rd_0a5", 1'b0, 13'h00A5, 8'h00, 8'h3C, 1'b0, verr);

    txn("b2b_wr_1fff", 1'b1, 13'h1FFF, 8'hFF, 8'h3C, 1'b1, verr);
    txn("b2b_rd_0000", 1'b0, 13'h0000, 8'h00, 8'h96, 1'b1, verr);
    txn("b2b_wr_0000", 1'b1, 13'h0000, 8'h00, 8'h96, 1'b0, verr);
    txn("rd_0000", 1'b0, 13'h0000, 8'h00, 8'h00, 1'b0, verr);
    txn("rd_1fff", 1'b0, 13'h1FFF, 8'h00, 8'hFF, 1'b0, verr);

    bus.REQ = 1'b1; bus.WE = 1'b1; bus.ADDR = 13'h00A6; bus.WDATA = 8'h5A;
    k = 0;
    while (nWE !== 1'b0 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check("abort.reached_pulse", nWE, 1'b0);
    nRESET = 1'b0;
    bus.REQ = 1'b0;
    #1;
    check("abort.nwe", nWE, 1'b1);
    check("abort.nce1", nCE1, 1'b1);
    check("abort.d_z", D, 8'hFF);
    check("abort.ready", bus.READY, 1'b0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (bus.ACK) acks++;
    end
    nRESET = 1'b1;
    @(negedge CLK);
    if (bus.ACK) acks++;
    check("abort.no_ack", acks, 0);
    check("abort.ready_after", bus.READY, 1'b1);
    txn("rd_0123", 1'b0, 13'h0123, 8'h00, 8'hB5, 1'b0, verr);

`ifdef CY6264_CTRL_VERIFY_EN
    corrupt_en = 1'b1;
    txn("vfy_bad", 1'b1, 13'h0010, 8'h55, 8'hB5, 1'b0, verr);
    check("vfy_bad.err", verr, 1'b1);
    txn("vfy_ok", 1'b1, 13'h0011, 8'hAA, 8'hB5, 1'b0, verr);
    check("vfy_ok.err", verr, 1'b0);
`endif

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
